// File: rtl/pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// pipe_stage_chain
//   Parametrised elastic pipeline-register chain. It replaces hand-written
//   per-stage pipeline registers (IF/ID, ID/EX, ...). Each of the STAGES
//   stages holds WIDTH payload bits plus a valid bit. Per-stage stall and
//   flush masks are supported, and bubbles collapse: a held stage only
//   blocks the stages that are full behind it, never the empty ones.
//
//   Optional feature: define PIPE_STAGE_CHAIN_STATS_EN to add the saturating
//   xfer_count / block_count statistics outputs.
//
// Parameters
//   WIDTH        payload bits per stage
//   STAGES       number of register stages (>=1); 0 = input side
//   CNT_W        occupancy width, always $clog2(STAGES+1) (not a parameter)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   in_valid     upstream offers in_data
//   in_data      upstream payload
//   in_ready     chain accepts in_data this cycle (no in_valid dependence)
//   out_valid    last stage holds a valid item
//   out_data     payload of the last stage
//   out_ready    downstream consumes out_data this cycle
//   stall_mask   bit i=1: stage i keeps its item this cycle
//   flush_mask   bit i=1: stage i is empty after this edge
//   stage_valid  valid bit of every stage
//   occupancy    number of valid stages (registered with the valid bits)
//   xfer_count   [STATS_EN] output transfers, saturating
//   block_count  [STATS_EN] cycles with in_valid & ~in_ready, saturating
// ---------------------------------------------------------------------------
module pipe_stage_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [WIDTH-1:0]                 out_data,
  input  logic                             out_ready,
  input  logic [STAGES-1:0]                stall_mask,
  input  logic [STAGES-1:0]                flush_mask,
  output logic [STAGES-1:0]                stage_valid,
  output logic [$clog2(STAGES+1)-1:0]      occupancy
`ifdef PIPE_STAGE_CHAIN_STATS_EN
  ,
  output logic [31:0]                      xfer_count,
  output logic [31:0]                      block_count
`endif
);

  localparam int CNT_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_nxt;
  logic [STAGES-1:0] move;      // stage i releases its item this cycle
  logic [STAGES-1:0] load;      // stage i captures the item from upstream
  logic [STAGES:0]   acc;       // acc[i]: stage i can take a new item
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [CNT_W-1:0]  occ_q;
  logic [CNT_W-1:0]  occ_nxt;

  // Ready ripples from the output back to the input. An empty stage is
  // always able to accept, which is what makes bubbles collapse.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so
    // no path leaves it unassigned and no latch is inferred.
    acc       = '0;
    move      = '0;
    load      = '0;
    valid_nxt = valid_q;
    occ_nxt   = '0;

    acc[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      move[i] = valid_q[i] & ~stall_mask[i] & acc[i+1];
      acc[i]  = ~valid_q[i] | move[i];
    end

    load[0] = in_valid & acc[0];
    for (int i = 1; i < STAGES; i++) begin
      load[i] = move[i-1];
    end

    // Flush wins over a load; the stage's own outgoing item has already
    // been accounted for in move[] and still lands downstream.
    for (int i = 0; i < STAGES; i++) begin
      if (flush_mask[i])  valid_nxt[i] = 1'b0;
      else if (load[i])   valid_nxt[i] = 1'b1;
      else if (move[i])   valid_nxt[i] = 1'b0;
    end

    // Count from the next-state bits so occupancy tracks stage_valid exactly.
    for (int i = 0; i < STAGES; i++) begin
      occ_nxt = occ_nxt + CNT_W'(valid_nxt[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      // NOTE: the stage data registers are cleared on reset because out_data
      // must read zero after reset; they are flops, not a RAM.
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_nxt;
      occ_q   <= occ_nxt;

      if (flush_mask[0])  data_q[0] <= '0;
      else if (load[0])   data_q[0] <= in_data;

      for (int i = 1; i < STAGES; i++) begin
        if (flush_mask[i])  data_q[i] <= '0;
        else if (load[i])   data_q[i] <= data_q[i-1];
      end
    end
  end

  assign in_ready    = acc[0];
  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign stage_valid = valid_q;
  assign occupancy   = occ_q;

`ifdef PIPE_STAGE_CHAIN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count  <= '0;
      block_count <= '0;
    end else begin
      if (move[STAGES-1] && (xfer_count != 32'hFFFF_FFFF)) begin
        xfer_count <= xfer_count + 32'd1;
      end
      if (in_valid && !acc[0] && (block_count != 32'hFFFF_FFFF)) begin
        block_count <= block_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_chain
//   Directed bench for pipe_stage_chain (WIDTH=32, STAGES=4). Expected output
//   items are pushed into a queue as stimulus is issued; an independent
//   monitor pops and compares on every output transfer. Direct checks cover
//   reset state, latency, occupancy, back-pressure, stall collapse, flush,
//   mid-stream reset and (with PIPE_STAGE_CHAIN_STATS_EN) the counters.
// ---------------------------------------------------------------------------
module tb_pipe_stage_chain;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int CNT_W  = $clog2(STAGES + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_ready;
  logic [STAGES-1:0] stall_mask;
  logic [STAGES-1:0] flush_mask;
  logic [STAGES-1:0] stage_valid;
  logic [CNT_W-1:0]  occupancy;
`ifdef PIPE_STAGE_CHAIN_STATS_EN
  logic [31:0]       xfer_count;
  logic [31:0]       block_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] expq [$];

  always #5 clk = ~clk;

  pipe_stage_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .stall_mask  (stall_mask),
    .flush_mask  (flush_mask),
    .stage_valid (stage_valid),
    .occupancy   (occupancy)
`ifdef PIPE_STAGE_CHAIN_STATS_EN
    ,
    .xfer_count  (xfer_count),
    .block_count (block_count)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change and state is inspected 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 30 && expq.size() != 0; c++) step();
    check(name, 64'(expq.size()), 64'd0);
  endtask

  // Monitor: an output transfer happens at the next edge when these hold.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !stall_mask[STAGES-1]) begin
      if (expq.size() == 0) begin
        check("out_unexpected_item", 64'(expq.size()), 64'd1);
      end else begin
        check("out_data_order", 64'(out_data), 64'(expq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    stall_mask = '0;
    flush_mask = '0;
    step();
    step();

    // ---- reset state
    check("rst_out_valid",   64'(out_valid),   64'd0);
    check("rst_out_data",    64'(out_data),    64'd0);
    check("rst_occupancy",   64'(occupancy),   64'd0);
    check("rst_in_ready",    64'(in_ready),    64'd1);
    check("rst_stage_valid", 64'(stage_valid), 64'd0);
    rst = 1'b0;

    // ---- back-to-back stream 1..8, first item visible after the 4th edge
    for (int k = 1; k <= 8; k++) expq.push_back(WIDTH'(k));
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(k);
      step();
      if (k < 4) begin
        check("stream_latency_early", 64'(out_valid), 64'd0);
      end else begin
        check("stream_out_valid", 64'(out_valid), 64'd1);
        check("stream_occupancy", 64'(occupancy), 64'd4);
      end
    end
    in_valid = 1'b0;
    drain("stream_drain");

    // ---- fill with out_ready=0, then release
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) expq.push_back(WIDTH'(32'h11 + k));
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(32'h11 + k);
      step();
    end
    in_valid = 1'b0;
    check("full_in_ready",    64'(in_ready),    64'd0);
    check("full_occupancy",   64'(occupancy),   64'd4);
    check("full_stage_valid", 64'(stage_valid), 64'hF);
    out_ready = 1'b1;
    #1;
    check("full_release_in_ready", 64'(in_ready), 64'd1);
    drain("full_drain");

    // ---- A, two idle cycles, B with the last stage stalled
    stall_mask = 4'b1000;
    expq.push_back(32'hA);
    expq.push_back(32'hB);
    in_valid = 1'b1; in_data = 32'hA; step();
    in_valid = 1'b0; step(); step();
    in_valid = 1'b1; in_data = 32'hB; step();
    in_valid = 1'b0; step(); step();
    check("stall_collapse_valid", 64'(stage_valid), 64'b1100);
    check("stall_collapse_occ",   64'(occupancy),   64'd2);
    step();
    check("stall_hold_valid", 64'(stage_valid), 64'b1100);
    check("stall_hold_data",  64'(out_data),    64'hA);
    stall_mask = 4'b1001;
    #1;
    check("stall_empty_stage_ready", 64'(in_ready), 64'd1);
    stall_mask = 4'b0000;
    step();
    check("stall_release_valid", 64'(out_valid), 64'd1);
    check("stall_release_data",  64'(out_data),  64'hB);
    drain("stall_drain");

    // ---- flush stages 0/1 while streaming 0x21..0x26 (0x22, 0x23 die)
    expq.push_back(32'h21);
    expq.push_back(32'h24);
    expq.push_back(32'h25);
    expq.push_back(32'h26);
    for (int k = 1; k <= 6; k++) begin
      in_valid   = 1'b1;
      in_data    = WIDTH'(32'h20 + k);
      flush_mask = (k == 3) ? 4'b0011 : 4'b0000;
      if (k == 3) check("flush_in_ready", 64'(in_ready), 64'd1);
      step();
      if (k == 3) begin
        check("flush_stage_valid", 64'(stage_valid), 64'b0100);
        check("flush_occupancy",   64'(occupancy),   64'd1);
      end
    end
    flush_mask = '0;
    in_valid   = 1'b0;
    drain("flush_drain");

    // ---- synchronous reset with three items in flight
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(32'h31 + k);
      step();
    end
    check("midrst_before_occ", 64'(occupancy), 64'd3);
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid",   64'(out_valid),   64'd0);
    check("midrst_occupancy",   64'(occupancy),   64'd0);
    check("midrst_in_ready",    64'(in_ready),    64'd1);
    check("midrst_stage_valid", 64'(stage_valid), 64'd0);
    check("midrst_out_data",    64'(out_data),    64'd0);
`ifdef PIPE_STAGE_CHAIN_STATS_EN
    check("midrst_xfer_count",  64'(xfer_count),  64'd0);
    check("midrst_block_count", 64'(block_count), 64'd0);
`endif
    repeat (10) step();
    check("midrst_no_ghost_valid", 64'(stage_valid), 64'd0);

    // ---- 10 transfers with 3 blocked input cycles
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) expq.push_back(WIDTH'(32'h40 + k));
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(32'h40 + k);
      step();
    end
    in_data = 32'h45;
    repeat (3) step();
    check("stats_blocked_full", 64'(stage_valid), 64'hF);
`ifdef PIPE_STAGE_CHAIN_STATS_EN
    check("stats_block_mid", 64'(block_count), 64'd3);
`endif
    out_ready = 1'b1;
    for (int k = 5; k <= 10; k++) begin
      in_data = WIDTH'(32'h40 + k);
      step();
    end
    in_valid = 1'b0;
    drain("stats_drain");
    step();
`ifdef PIPE_STAGE_CHAIN_STATS_EN
    check("stats_xfer_count",  64'(xfer_count),  64'd10);
    check("stats_block_count", 64'(block_count), 64'd3);
`endif
    check("final_queue_empty", 64'(expq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
